// File: rtl/word_demux_pkg.sv
// word_demux_pkg: shared constants and state encoding for the word-to-byte
// demultiplexer (word_byte_demux) and its word FIFO (word_fifo).
package word_demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int BYTE_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int NBYTES     = DATA_W_DEF / BYTE_W_DEF;
  localparam int IDX_W      = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_fifo.sv
// word_fifo: DEPTH x DATA_W synchronous FIFO with registered occupancy count.
// The occupancy count is the only full/empty indication; the pointers simply
// wrap modulo DEPTH (a power of two). The caller only pops when the count is
// non-zero and only pushes when there is room (or a pop happens on the same edge).
module word_fifo
  import word_demux_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [CNT_W-1:0]  o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end else begin
      r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
    end
  end

  // Pointers advance independently and wrap naturally at DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else        r_wr_ptr <= r_wr_ptr;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      else        r_rd_ptr <= r_rd_ptr;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/word_byte_demux.sv
// word_byte_demux: buffers valid 32-bit words in word_fifo and unstripes each
// into bytes, MSB byte first, with a valid/ready handshake on the byte side.
// The last byte of a word hands straight over to the next buffered word, so a
// word every NBYTES cycles streams without bubbles.
// Optional build macro WORD_DEMUX_PARITY_EN adds parity_out, the even parity
// of byte_out, registered alongside it.
module word_byte_demux
  import word_demux_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BYTE_W  = BYTE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              byte_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              valid_out,
  output logic [IDX_W-1:0]  byte_idx,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow
`ifdef WORD_DEMUX_PARITY_EN
  ,
  output logic              parity_out
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W / BYTE_W - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic              r_overflow;

  logic [DATA_W-1:0] w_fifo_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_xfer;
  logic              w_last;
  logic              w_push;
  logic              w_pop;
  logic              w_load;
  logic              w_advance;
  logic              w_clear;

  assign w_empty = (w_count == CNT_W'(0));
  assign w_xfer  = r_valid && byte_ready;
  assign w_last  = (r_idx == LAST_IDX);
  // A full FIFO still accepts a word when the same edge pops one.
  assign w_push  = valid_in && ((w_count < CNT_W'(DEPTH)) || w_pop);

  word_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .i_clk     (clk_4f),
    .i_rst_n   (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (data_in),
    .o_rd_data (w_fifo_data),
    .o_count   (w_count)
  );

  // State register.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: leave SEND only when the last byte goes and nothing is queued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!w_empty) w_state_next = SEND;
        else          w_state_next = IDLE;
      end
      SEND: begin
        if (w_xfer && w_last && w_empty) w_state_next = IDLE;
        else                             w_state_next = SEND;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath controls: pop/load a new word, step to the next byte, or go quiet.
  always_comb begin
    w_pop     = 1'b0;
    w_load    = 1'b0;
    w_advance = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
        end else begin
          w_clear = 1'b1;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (!w_last) begin
            w_advance = 1'b1;
          end else if (!w_empty) begin
            w_pop  = 1'b1;
            w_load = 1'b1;
          end else begin
            w_clear = 1'b1;
          end
        end else begin
          w_advance = 1'b0;
        end
      end
      default: w_clear = 1'b1;
    endcase
  end

  // Output registers: the current byte is always the top slice of the shift register.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_shift <= w_fifo_data;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (w_advance) begin
      r_shift <= r_shift << BYTE_W;
      r_idx   <= r_idx + IDX_W'(1);
      r_valid <= 1'b1;
    end else if (w_clear) begin
      r_shift <= r_shift;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_shift <= r_shift;
      r_idx   <= r_idx;
      r_valid <= r_valid;
    end
  end

  // Sticky overflow: set whenever a valid word cannot be stored.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)                    r_overflow <= 1'b0;
    else if (valid_in && !w_push)  r_overflow <= 1'b1;
    else                           r_overflow <= r_overflow;
  end

  assign byte_out  = r_shift[DATA_W-1 -: BYTE_W];
  assign valid_out = r_valid;
  assign byte_idx  = r_idx;
  assign fifo_count = w_count;
  assign overflow  = r_overflow;

`ifdef WORD_DEMUX_PARITY_EN
  logic r_parity;

  function automatic logic even_parity(input logic [BYTE_W-1:0] b);
    even_parity = ^b;
  endfunction

  // Parity tracks the byte that will be presented next, so it lines up with byte_out.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset)         r_parity <= 1'b0;
    else if (w_load)    r_parity <= even_parity(w_fifo_data[DATA_W-1 -: BYTE_W]);
    else if (w_advance) r_parity <= even_parity(r_shift[DATA_W-BYTE_W-1 -: BYTE_W]);
    else                r_parity <= r_parity;
  end

  assign parity_out = r_parity;
`endif

endmodule
